// File: rtl/tank_vga_pkg.sv
// Shared constants and types for the tank VGA timing generator.
// Holds 640x480@60 defaults, sync windows, coordinate type and helper.
package tank_vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_TOTAL_DEF   = 800;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_TOTAL_DEF   = 525;

    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    typedef logic [CNT_W-1:0] coord_t;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(
        input coord_t v,
        input coord_t lo,
        input coord_t hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/tank_vga_axis_counter.sv
// Single-axis counter: counts 0..TOTAL-1 while en, then wraps to 0.
// Ports: clk, rst_n, en in; cnt (current value), wrap (last count & en) out.
module tank_vga_axis_counter
    import tank_vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t cnt,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    coord_t cnt_q;
    coord_t cnt_d;

    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tank_vga_timing.sv
// VGA raster timing generator with registered, mutually aligned outputs.
// Ports: vga_clk, reset_n in; hs, vs, blank, DrawX, DrawY, frame_start,
// line_start out; frame_count out only when VGA_FRAME_CNT_EN is defined.
module tank_vga_timing
    import tank_vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int HS_BEGIN  = H_SYNC_START,
    parameter int HS_END    = H_SYNC_END,
    parameter int VS_BEGIN  = V_SYNC_START,
    parameter int VS_END    = V_SYNC_END
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    if (H_VISIBLE > 1023 || H_TOTAL > 1023 ||
        V_VISIBLE > 1023 || V_TOTAL > 1023 ||
        HS_BEGIN > 1023 || HS_END > 1023 ||
        VS_BEGIN > 1023 || VS_END > 1023) begin : g_bad_param
        $error("tank_vga_timing: parameter exceeds 10-bit range");
    end

    localparam coord_t HV  = coord_t'(H_VISIBLE);
    localparam coord_t VV  = coord_t'(V_VISIBLE);
    localparam coord_t HSB = coord_t'(HS_BEGIN);
    localparam coord_t HSE = coord_t'(HS_END);
    localparam coord_t VSB = coord_t'(VS_BEGIN);
    localparam coord_t VSE = coord_t'(VS_END);

    coord_t hc;
    coord_t vc;
    logic   h_wrap;
    logic   v_wrap;

    tank_vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (1'b1),
        .cnt   (hc),
        .wrap  (h_wrap)
    );

    tank_vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (h_wrap),
        .cnt   (vc),
        .wrap  (v_wrap)
    );

    // Tracks "counters sit at (0,0)": true out of reset and after every
    // vertical wrap, so frame detection needs no extra 20-bit compare.
    logic at_origin_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            at_origin_q <= 1'b1;
        end else begin
            at_origin_q <= v_wrap;
        end
    end

    logic   hs_d, vs_d, blank_d, fs_d, ls_d;
    logic   hs_q, vs_q, blank_q, fs_q, ls_q;
    coord_t x_q, y_q;

    always_comb begin
        hs_d    = !in_window(hc, HSB, HSE);
        vs_d    = !in_window(vc, VSB, VSE);
        blank_d = (hc < HV) && (vc < VV);
        ls_d    = (hc == '0);
        fs_d    = at_origin_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            x_q     <= hc;
            y_q     <= vc;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;

`ifdef VGA_FRAME_CNT_EN
    // Steps on the same edge that raises frame_start, so it stays aligned.
    logic [7:0] frame_count_q;
    logic [7:0] frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (fs_d) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_tank_vga_timing.sv
// Directed bench: default 640x480 instance for line/reset behaviour and a
// small-raster instance for whole-frame and frame-counter behaviour.
module tb_tank_vga_timing;

    logic       clk;
    logic       rst_n;
    logic       rst_s;

    logic       hs, vs, blank, fs, ls;
    logic [9:0] dx, dy;
    logic       s_hs, s_vs, s_blank, s_fs, s_ls;
    logic [9:0] s_dx, s_dy;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc, s_fc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tank_vga_timing u_dut (
        .vga_clk     (clk),
        .reset_n     (rst_n),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .DrawX       (dx),
        .DrawY       (dy),
        .frame_start (fs),
        .line_start  (ls)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (fc)
`endif
    );

    // 20 x 10 raster: visible 16x6, hsync cols 17..18, vsync line 7.
    tank_vga_timing #(
        .H_VISIBLE (16),
        .H_TOTAL   (20),
        .V_VISIBLE (6),
        .V_TOTAL   (10),
        .HS_BEGIN  (17),
        .HS_END    (19),
        .VS_BEGIN  (7),
        .VS_END    (8)
    ) u_small (
        .vga_clk     (clk),
        .reset_n     (rst_s),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .DrawX       (s_dx),
        .DrawY       (s_dy),
        .frame_start (s_fs),
        .line_start  (s_ls)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (s_fc)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_small_fs();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_fs && n < 1000);
        check("small_fs_wait", int'(s_fs), 1);
    endtask

    int hs_first, hs_cnt;
    int n_cyc, vs_cnt, vs_first, hs_tot, blank_bad, max_x, max_y;

    initial begin
        rst_n = 1'b0;
        rst_s = 1'b0;
        repeat (3) tick();

        check("rst_dx", int'(dx), 0);
        check("rst_dy", int'(dy), 0);
        check("rst_hs", int'(hs), 1);
        check("rst_vs", int'(vs), 1);
        check("rst_blank", int'(blank), 0);
        check("rst_fs", int'(fs), 0);
        check("rst_ls", int'(ls), 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_dx", int'(dx), 0);
        check("rel_dy", int'(dy), 0);
        check("rel_blank", int'(blank), 1);
        check("rel_fs", int'(fs), 1);
        check("rel_ls", int'(ls), 1);
        check("rel_hs", int'(hs), 1);
        check("rel_vs", int'(vs), 1);

        hs_first = -1;
        hs_cnt   = 0;
        for (int x = 1; x < 800; x++) begin
            tick();
            if (x == 1) check("x1_fs", int'(fs), 0);
            if (x == 639) check("blank_639", int'(blank), 1);
            if (x == 640) check("blank_640", int'(blank), 0);
            if (!hs) begin
                if (hs_cnt == 0) hs_first = int'(dx);
                hs_cnt++;
            end
        end
        check("x799_dx", int'(dx), 799);
        check("x799_dy", int'(dy), 0);
        check("hs_first", hs_first, 656);
        check("hs_len", hs_cnt, 96);

        tick();
        check("wrap_dx", int'(dx), 0);
        check("wrap_dy", int'(dy), 1);
        check("wrap_ls", int'(ls), 1);
        check("wrap_fs", int'(fs), 0);
        check("wrap_blank", int'(blank), 1);

        repeat (300) tick();
        check("mid_dx", int'(dx), 300);
        check("mid_dy", int'(dy), 1);
        check("mid_blank", int'(blank), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dx", int'(dx), 0);
        check("async_dy", int'(dy), 0);
        check("async_blank", int'(blank), 0);
        check("async_hs", int'(hs), 1);
        repeat (2) tick();
        check("held_dx", int'(dx), 0);
        check("held_ls", int'(ls), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("restart_dx", int'(dx), 0);
        check("restart_dy", int'(dy), 0);
        check("restart_fs", int'(fs), 1);
        tick();
        check("restart_dx1", int'(dx), 1);

        @(negedge clk);
        rst_s = 1'b1;
        tick();
        check("s_rel_fs", int'(s_fs), 1);
`ifdef VGA_FRAME_CNT_EN
        check("fc_1", int'(s_fc), 1);
`endif
        n_cyc     = 0;
        vs_cnt    = 0;
        vs_first  = -1;
        hs_tot    = 0;
        blank_bad = 0;
        max_x     = 0;
        max_y     = 0;
        do begin
            if (!s_vs) begin
                if (vs_cnt == 0) vs_first = int'(s_dy);
                vs_cnt++;
            end
            if (!s_hs) hs_tot++;
            if (s_dy >= 10'd6 && s_blank) blank_bad++;
            if (int'(s_dx) > max_x) max_x = int'(s_dx);
            if (int'(s_dy) > max_y) max_y = int'(s_dy);
            tick();
            n_cyc++;
        end while (!s_fs && n_cyc < 1000);
        check("s_period", n_cyc, 200);
        check("s_vs_first", vs_first, 7);
        check("s_vs_len", vs_cnt, 20);
        check("s_hs_total", hs_tot, 20);
        check("s_blank_bot", blank_bad, 0);
        check("s_max_x", max_x, 19);
        check("s_max_y", max_y, 9);
        check("s_wrap_dy", int'(s_dy), 0);
`ifdef VGA_FRAME_CNT_EN
        check("fc_2", int'(s_fc), 2);
        for (int f = 3; f <= 255; f++) wait_small_fs();
        check("fc_255", int'(s_fc), 255);
        wait_small_fs();
        check("fc_wrap", int'(s_fc), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_vga_timing.md
TANK_VGA_TIMING -- requirements
Module: tank_vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have port vga_clk  input  1  pixel clock; sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port hs  output  1  horizontal sync, active low.
REQ-008 SHALL have port vs  output  1  vertical sync, active low.
REQ-009 SHALL have port blank  output  1  1 = visible pixel (draw enable), 0 = blanking.
REQ-010 SHALL have port DrawX  output  10  current pixel column.
REQ-011 SHALL have port DrawY  output  10  current pixel row.
REQ-012 SHALL have port frame_start  output  1  one-clock pulse at pixel (0,0).
REQ-013 SHALL have port line_start  output  1  one-clock pulse at column 0 of every line.

Function
REQ-014 SHALL keep internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1); hc increments every clock.
REQ-015 SHALL wrap hc from H_TOTAL-1 to 0 and increment vc in the same cycle; vc wraps from V_TOTAL-1 to 0 when hc wraps.
REQ-016 SHALL register all outputs from hc/vc: one-clock latency; output set at cycle n reflects counter values at cycle n-1, and all outputs are mutually aligned.
REQ-017 SHALL drive DrawX=hc, DrawY=vc (registered), including blanking region (values up to 799/524).
REQ-018 SHALL drive hs=0 iff H_SYNC_START <= hc < H_SYNC_END (656..751 default), else 1.
REQ-019 SHALL drive vs=0 iff V_SYNC_START <= vc < V_SYNC_END (490..491 default), else 1.
REQ-020 SHALL drive blank=1 iff hc < H_VISIBLE and vc < V_VISIBLE.
REQ-021 SHALL pulse frame_start=1 iff hc==0 and vc==0; line_start=1 iff hc==0 (both pulses coincide at frame start).
REQ-022 SHALL use 10-bit unsigned compares; no parameter value may exceed 1023 (elaboration check).

Reset
REQ-023 SHALL, while reset_n=0, hold hc=vc=0, DrawX=DrawY=0, hs=vs=1, blank=0, frame_start=line_start=0.
REQ-024 SHALL, on the first edge after release, output DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
REQ-025 SHALL, on reset assertion mid-frame, force reset values immediately (asynchronous) and restart at (0,0).

Configuration
REQ-026 SHALL, with VGA_FRAME_CNT_EN defined, add output frame_count (8 bits) that resets to 0, increments on each frame_start output edge (the pulse at (0,0)), and wraps 255->0; without the macro, the port and counter do not exist and all other behaviour is identical.

Structure
REQ-027 SHALL place H_SYNC_START/H_SYNC_END/V_SYNC_START/V_SYNC_END constants and 640x480 defaults in shared package tank_vga_pkg.
REQ-028 SHALL implement hc and vc as two instances of sub-module tank_vga_axis_counter (terminal-count wrap, enable input, wrap-pulse output).

Verification
REQ-029 SHALL verify reset release: first edge -> DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1.
REQ-030 SHALL verify line: DrawX 639 -> blank=1; 640 -> blank=0; hs low for exactly 96 clocks starting at DrawX=656; wrap after 799 with DrawY+1.
REQ-031 SHALL verify frame: vs low for exactly 2 lines (DrawY 490..491); frame period = 420000 clocks; blank=0 for every DrawY >= 480.
REQ-032 SHALL verify reset mid-frame at DrawX=300, DrawY=200: outputs go to reset values without waiting for an edge; restart at (0,0) after release.
REQ-033 SHALL verify with VGA_FRAME_CNT_EN: frame_count 0 -> 1 -> 2 across two frames and 255 -> 0 wrap; without macro, build succeeds with no frame_count port.
